layer_1_activation_serializer: RTL
==================================

Name: layer_1_activation_serializer

Overview:
Downstream neighbour of the layer-1 bias-add stage. Captures the 20 biased layer-1 accumulator words in one cycle when the bias-add stage pulses its completion flag. Applies ReLU and a saturating requantise from 16-bit signed fixed point to 8-bit unsigned. Streams the 20 activations one per beat over a valid/ready handshake to the layer-2 MAC input.

Parameters:
- SIZE, 16, width of each signed two's-complement input word
- NUM_NEURONS, 20, number of neurons captured and streamed per frame
- OUT_SIZE, 8, width of each unsigned activation output
- FRAC_SHIFT, 4, arithmetic right shift applied during requantise; must be >= 1
- IDX_W, 5, width of the neuron index; must satisfy 2^IDX_W >= NUM_NEURONS

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  single-cycle capture strobe, driven from the bias-add done flag
- in_data  in  NUM_NEURONS*SIZE  flattened neuron words; neuron k occupies bits [k*SIZE +: SIZE]
- in_ready  out  1  high when a capture is accepted
- out_valid  out  1  out_data/out_index/out_last are valid
- out_ready  in  1  consumer accepts the current beat
- out_data  out  OUT_SIZE  activation of neuron out_index
- out_index  out  IDX_W  neuron number of the current beat, 0..NUM_NEURONS-1
- out_last  out  1  high on the beat with out_index == NUM_NEURONS-1
- busy  out  1  high while a frame is held or being streamed

Behaviour:
- Clock is clk. reset is synchronous and active-high.
- Reset values: state IDLE, out_valid 0, out_data 0, out_index 0, out_last 0, busy 0, all buffer entries 0.
- in_ready = (state==IDLE) & ~reset. It is combinational.
- The FSM has two states: IDLE and STREAM.
- IDLE:
  - On in_valid & in_ready at clock edge T, activate all NUM_NEURONS words into the OUT_SIZE-wide buffer.
  - At the same edge: state <= STREAM, out_index <= 0, out_data <= act(word0), out_valid <= 1, busy <= 1, out_last <= (NUM_NEURONS==1).
  - Latency: first beat is valid in the cycle after the capture edge.
  - in_valid without in_ready is a no-op.
- Activation act(x), with x signed SIZE bits:
  - If x[SIZE-1]==1 (negative), the result is 0.
  - Otherwise y = x >> FRAC_SHIFT. If y > 2^OUT_SIZE-1, the result is 2^OUT_SIZE-1 (saturate); else the result is y[OUT_SIZE-1:0].
  - Zero maps to 0.
- STREAM:
  - A beat transfers on an edge where out_valid & out_ready.
  - While out_valid & ~out_ready, out_data, out_index and out_last hold stable.
  - On a transfer with out_index < NUM_NEURONS-1: out_index increments, out_data <= buffer[out_index+1], and out_last updates.
  - On the transfer with out_last==1: state <= IDLE, out_valid <= 0, busy <= 0, out_last <= 0, out_index <= 0. out_data holds its last value.
  - With continuous out_ready, the beats occupy NUM_NEURONS consecutive cycles.
- in_valid during STREAM is ignored (in_ready=0). The frame is dropped; no error flag.
- A new capture is accepted no earlier than the cycle after the last transfer. There is no overlap with the final beat.
- Reset mid-frame aborts immediately. The next cycle shows reset values; the buffer is cleared and remaining beats are discarded.
- Only one frame is buffered. There is no FIFO.

Optional Feature:
LAYER_1_ACT_ROUND_EN
- Defined: for non-negative x, y = (x + 2^(FRAC_SHIFT-1)) >> FRAC_SHIFT. The addition is computed in SIZE+1 bits so 0x7FFF cannot wrap. Saturation applies afterwards.
- Undefined: y is truncated, x >> FRAC_SHIFT.
- Ports, latency and handshake are identical in both builds.

Test Plan:
1. Reset check: assert reset 2 cycles -> out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, in_ready=0 during reset and 1 after.
2. Basic frame with out_ready=1: word0=0x0100, word1=0xFF00, word2=0x7FFF, word3=0x0018, others 0x0010; pulse in_valid at edge T -> beats on cycles T+1..T+20 with out_data 0x10, 0x00, 0xFF, 0x01, then 0x01 ...; out_last only at index 19; in_ready=1 from T+21.
3. Backpressure: hold out_ready=0 for 3 cycles while out_index=5 -> out_data, out_index and out_valid stable; index 6 follows the first ready edge; total 20 beats, none duplicated or lost.
4. Ignored strobe: pulse in_valid with different data at index 10 -> no effect; remaining beats carry the original frame values.
5. Mid-frame reset: reset at index 7 -> next cycle out_valid=0, busy=0; a new frame then streams correctly from index 0.
6. Rounding: word3=0x0018 and word0=0x0FF8 -> with LAYER_1_ACT_ROUND_EN, 0x02 and 0xFF (saturated); without it, 0x01 and 0xFF.

Source files
------------

// File: rtl/layer_1_activation_serializer.sv
`timescale 1ns/1ps
// layer_1_activation_serializer
//
// Sits after the layer-1 bias-add stage. When the bias-add stage pulses its
// done flag, this block captures all NUM_NEURONS signed accumulator words in a
// single cycle. Each word goes through ReLU and a saturating requantise from
// SIZE-bit signed fixed point to OUT_SIZE-bit unsigned. The resulting
// activations are streamed one per beat over a valid/ready handshake to the
// layer-2 MAC input.
//
// Optional build macro:
//   LAYER_1_ACT_ROUND_EN - round to nearest (add half an LSB before shifting)
//                          instead of truncating. Ports, latency and handshake
//                          are the same in both builds.
//
// Ports:
//   clk        - clock
//   reset      - synchronous, active-high reset
//   in_valid   - single-cycle capture strobe (bias-add done flag)
//   in_data    - flattened neuron words, neuron k at [k*SIZE +: SIZE]
//   in_ready   - high when a capture would be accepted (IDLE and not in reset)
//   out_valid  - out_data/out_index/out_last are valid
//   out_ready  - consumer accepts the current beat
//   out_data   - activation of neuron out_index
//   out_index  - neuron number of the current beat
//   out_last   - high on the beat for neuron NUM_NEURONS-1
//   busy       - high while a frame is held or being streamed
module layer_1_activation_serializer #(
    parameter int SIZE        = 16,
    parameter int NUM_NEURONS = 20,
    parameter int OUT_SIZE    = 8,
    parameter int FRAC_SHIFT  = 4,
    parameter int IDX_W       = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [NUM_NEURONS*SIZE-1:0] in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_SIZE-1:0]         out_data,
    output logic [IDX_W-1:0]            out_index,
    output logic                        out_last,
    output logic                        busy
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    logic [0:0]          state_reg;
    logic [OUT_SIZE-1:0] buf_reg [NUM_NEURONS];
    logic [OUT_SIZE-1:0] act_w   [NUM_NEURONS];
    logic                out_valid_reg;
    logic                out_last_reg;
    logic                busy_reg;
    logic [OUT_SIZE-1:0] out_data_reg;
    logic [IDX_W-1:0]    out_index_reg;
    logic [IDX_W-1:0]    index_next;
    logic                capture;
    logic                xfer;

    // Per-neuron activation. The word is zero-extended to SIZE+1 bits before
    // any rounding offset is added so that the largest positive input cannot
    // wrap into the sign position.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_act
            logic [SIZE-1:0] word;
            logic [SIZE:0]   biased;
            logic [SIZE:0]   shifted;

            assign word = in_data[gi*SIZE +: SIZE];
`ifdef LAYER_1_ACT_ROUND_EN
            assign biased = {1'b0, word} + ((SIZE+1)'(1) << (FRAC_SHIFT - 1));
`else
            assign biased = {1'b0, word};
`endif
            assign shifted = biased >> FRAC_SHIFT;

            // Negative -> 0; anything with bits above the output width -> full scale.
            assign act_w[gi] = word[SIZE-1]               ? '0 :
                               (|shifted[SIZE:OUT_SIZE]) ? '1 :
                               shifted[OUT_SIZE-1:0];
        end
    endgenerate

    assign in_ready   = (state_reg == IDLE) & ~reset;
    assign capture    = in_valid & in_ready;
    assign xfer       = out_valid_reg & out_ready;
    assign index_next = out_index_reg + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            out_data_reg  <= '0;
            out_index_reg <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                buf_reg[k] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (capture) begin
                        for (int k = 0; k < NUM_NEURONS; k++) begin
                            buf_reg[k] <= act_w[k];
                        end
                        // Neuron 0 is presented straight from the activation
                        // logic so the first beat is valid one cycle after capture.
                        state_reg     <= STREAM;
                        out_index_reg <= '0;
                        out_data_reg  <= act_w[0];
                        out_valid_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        out_last_reg  <= (NUM_NEURONS == 1);
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (out_last_reg) begin
                            // out_data intentionally keeps the final activation.
                            state_reg     <= IDLE;
                            out_valid_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            out_last_reg  <= 1'b0;
                            out_index_reg <= '0;
                        end else begin
                            out_index_reg <= index_next;
                            out_data_reg  <= buf_reg[index_next];
                            out_last_reg  <= (index_next == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_index = out_index_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;

endmodule
